apb2reg_bridge: RTL and testbench
=================================

APB2REG_BRIDGE -- requirements
Module: apb2reg_bridge

Interface
REQ-001 Parameter WAIT_STATES, default 1, meaning idle cycles between address capture and the register strobe (legal 0..15).
REQ-002 Parameter ADDR_LIMIT, default 10'h3FC, meaning the highest legal word address; higher addresses are errors.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB enable (access phase).
REQ-007 pwrite  input  1  APB direction (1 = write).
REQ-008 paddr  input  12  APB byte address.
REQ-009 pwdata  input  32  APB write data.
REQ-010 pready  output  1  APB transfer-complete.
REQ-011 prdata  output  32  APB read data (registered).
REQ-012 pslverr  output  1  APB error response.
REQ-013 wr_en  output  1  register-file write strobe.
REQ-014 rd_en  output  1  register-file read strobe.
REQ-015 addr  output  10  register-file address.
REQ-016 wdata  output  32  register-file write data.
REQ-017 rdata  input  32  register-file combinational read data.

Function
REQ-018 FSM states SHALL be IDLE, WAIT, STROBE and RESP.
REQ-019 IDLE: on psel=1 and penable=0, capture paddr, pwrite and pwdata, and go to WAIT (or STROBE if WAIT_STATES=0).
REQ-020 WAIT: a 4-bit counter SHALL count WAIT_STATES cycles, then go to STROBE.
REQ-021 Error is flagged at capture if paddr[1:0]!=0, paddr[11:10]!=0, or paddr[9:0]>ADDR_LIMIT.
REQ-022 STROBE, no error: assert wr_en (write) or rd_en (read) for exactly one cycle, with addr = captured paddr[9:0] and wdata = captured pwdata.
REQ-023 STROBE, error: no strobe is asserted and the register file is untouched.
REQ-024 STROBE, read: prdata SHALL load rdata at the end of the cycle; for writes and errors prdata loads 0.
REQ-025 RESP: pready=1 and pslverr=error flag for exactly one cycle, then return to IDLE.
REQ-026 Latency: with setup in cycle T, the strobe is at T+1+WAIT_STATES and pready at T+2+WAIT_STATES.
REQ-027 pready and pslverr SHALL be 0 in every state other than RESP.
REQ-028 If psel drops in WAIT or STROBE, the FSM returns to IDLE next cycle and issues no later strobe or pready.
REQ-029 A new setup is accepted directly from IDLE in the cycle after RESP; back-to-back transfers lose no cycle beyond the protocol.
REQ-030 addr and wdata SHALL hold their captured values until the next capture; wr_en and rd_en are never both 1.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, counter=0, error flag=0, wr_en=rd_en=pready=pslverr=0, prdata=0, addr=0, wdata=0.
REQ-032 Reset in any state SHALL abort the transfer with no strobe; normal operation resumes on the first setup after rst falls.

Structure
REQ-033 The FSM state encoding, the WAIT_STATES default and the ADDR_LIMIT default belong in the shared package apb2reg_pkg.
REQ-034 The error check is one sub-module, apb2reg_addr_chk (combinational: paddr in, error out); everything else is flat.

Verification
REQ-035 Write 0xDEADBEEF to 0x000 with WAIT_STATES=1 -> wr_en at T+2 with addr=0 and wdata=0xDEADBEEF; pready=1 and pslverr=0 at T+3.
REQ-036 Read 0x004 with rdata=0x12345678 -> rd_en at T+2; prdata=0x12345678 and pready at T+3.
REQ-037 Write to 0x002 (misaligned) and read 0x400 (out of range) -> no strobe; pslverr=1 with pready; prdata=0.
REQ-038 WAIT_STATES=0 with two back-to-back writes -> strobes at T+1 and T+4; pready at T+2 and T+5.
REQ-039 rst asserted in WAIT -> no wr_en and all outputs 0; a following read of 0x000 completes normally.
REQ-040 psel dropped during WAIT -> no strobe and no pready; FSM is in IDLE the next cycle.

Source files
------------

// File: rtl/apb2reg_pkg.sv
// Shared definitions for the APB-to-register-file bridge: FSM encoding and
// parameter defaults used by the bridge and its address checker.
package apb2reg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STROBE = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int         WAIT_STATES_DEF = 1;
   localparam logic [9:0] ADDR_LIMIT_DEF  = 10'h3FC;

endpackage

// File: rtl/apb2reg_addr_chk.sv
// Combinational legality check of an APB byte address: word alignment,
// upper bits clear and word address within ADDR_LIMIT.
module apb2reg_addr_chk
   import apb2reg_pkg::*;
#(
   parameter logic [9:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
   input  logic [11:0] paddr,
   output logic        err
);

   assign err = (paddr[1:0] != 2'b00)
             || (paddr[11:10] != 2'b00)
             || (paddr[9:0] > ADDR_LIMIT);

endmodule

// File: rtl/apb2reg_bridge.sv
// APB slave that turns each transfer into a single-cycle register-file
// strobe after WAIT_STATES idle cycles, then answers with a one-cycle pready.
module apb2reg_bridge
   import apb2reg_pkg::*;
#(
   parameter int         WAIT_STATES = WAIT_STATES_DEF,
   parameter logic [9:0] ADDR_LIMIT  = ADDR_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [11:0] paddr,
   input  logic [31:0] pwdata,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr,
   output logic        wr_en,
   output logic        rd_en,
   output logic [9:0]  addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       err_q;
   logic       write_q;
   logic       setup_err;
   logic       setup;

   assign setup = psel && !penable;

   apb2reg_addr_chk #(
      .ADDR_LIMIT (ADDR_LIMIT)
   ) u_addr_chk (
      .paddr (paddr),
      .err   (setup_err)
   );

   // All outputs are registered: strobes and pready are raised on the
   // transition into the state that owns them, so they last one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= 32'h0;
         addr    <= 10'h0;
         wdata   <= 32'h0;
      end else begin
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         case (state)
            IDLE: begin
               if (setup) begin
                  addr    <= paddr[9:0];
                  wdata   <= pwdata;
                  write_q <= pwrite;
                  err_q   <= setup_err;
                  cnt     <= 4'd0;
                  if (WAIT_STATES == 0) begin
                     state <= STROBE;
                     wr_en <= pwrite && !setup_err;
                     rd_en <= !pwrite && !setup_err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!psel) begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end else if (cnt == WAIT_LAST) begin
                  state <= STROBE;
                  cnt   <= 4'd0;
                  wr_en <= write_q && !err_q;
                  rd_en <= !write_q && !err_q;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            STROBE: begin
               // rdata is combinational from addr, valid while the strobe is up
               prdata <= (!write_q && !err_q) ? rdata : 32'h0;
               if (!psel) begin
                  state <= IDLE;
               end else begin
                  state   <= RESP;
                  pready  <= 1'b1;
                  pslverr <= err_q;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb2reg_bridge.sv
// Bench for apb2reg_bridge: directed vector table, reset/abort sequences,
// a WAIT_STATES=0 back-to-back sequence and randomized transfers.
module tb_apb2reg_bridge;

   logic        clk = 1'b0;
   logic        rst, clr;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic        pready, pslverr, wr_en, rd_en;
   logic [31:0] prdata, wdata, rdata;
   logic [9:0]  addr;

   logic        psel0, penable0, pwrite0;
   logic [11:0] paddr0;
   logic [31:0] pwdata0;
   logic        pready0, pslverr0, wr_en0, rd_en0;
   logic [31:0] prdata0, wdata0;
   logic [31:0] rdata0 = 32'h0;
   logic [9:0]  addr0;

   logic [31:0] regf [0:255];
   logic [31:0] mdl  [0:255];

   int n_chk = 0;
   int n_pass = 0;
   int both_cnt = 0;
   int viol = 0;

   always #5 clk = ~clk;

   apb2reg_bridge dut (
      .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
      .pslverr(pslverr), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wdata(wdata), .rdata(rdata)
   );

   apb2reg_bridge #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
      .paddr(paddr0), .pwdata(pwdata0), .pready(pready0), .prdata(prdata0),
      .pslverr(pslverr0), .wr_en(wr_en0), .rd_en(rd_en0), .addr(addr0),
      .wdata(wdata0), .rdata(rdata0)
   );

   // Register file behind the bridge
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) regf[i] <= 32'h0;
      end else if (wr_en) begin
         regf[addr[9:2]] <= wdata;
      end
   end
   assign rdata = regf[addr[9:2]];

   always @(negedge clk) begin
      if (wr_en && rd_en) both_cnt <= both_cnt + 1;
      if (pslverr && !pready) viol <= viol + 1;
   end

   typedef struct {
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      logic        err;
      logic [31:0] prd;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic mdl_err(input logic [11:0] a);
      int ai;
      ai = int'(a);
      return (ai % 4 != 0) || (ai >= 'h400) || (ai > 'h3FC);
   endfunction

   // One transfer on dut; cycle k=1 is the cycle after setup.
   task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input int drop_k, output int sk, output int ns, output logic sw,
                       output int rk, output logic re, output logic [31:0] rd,
                       output logic [9:0] sa, output logic [31:0] sd);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      sk = -1; ns = 0; rk = -1; sw = 1'b0; re = 1'b0; rd = 32'h0; sa = 10'h0; sd = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (wr_en || rd_en) begin
            if (sk < 0) begin
               sk = k; sw = wr_en; sa = addr; sd = wdata;
            end
            ns++;
         end
         if (pready && rk < 0) begin
            rk = k; re = pslverr; rd = prdata;
         end
         if (k == drop_k) begin
            psel = 1'b0; penable = 1'b0;
            break;
         end
         penable = 1'b1;
         if (rk == k) break;
      end
   endtask

   task automatic do_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input logic e, input logic [31:0] prd, input string tag);
      int sk, ns, rk;
      logic sw, re;
      logic [31:0] rd, sd;
      logic [9:0] sa;
      xfer(w, a, d, 0, sk, ns, sw, rk, re, rd, sa, sd);
      chk({tag, ".strobe_cycle"}, sk, e ? -1 : 2);
      chk({tag, ".strobe_count"}, ns, e ? 0 : 1);
      if (!e) begin
         chk({tag, ".strobe_dir"}, sw, w);
         chk({tag, ".addr"}, sa, a[9:0]);
         if (w) chk({tag, ".wdata"}, sd, d);
      end
      chk({tag, ".pready_cycle"}, rk, 3);
      chk({tag, ".pslverr"}, re, e);
      chk({tag, ".prdata"}, rd, prd);
      if (w && !e) mdl[a[9:2]] = d;
   endtask

   initial begin
      int sk, ns, rk, stray;
      logic sw, re;
      logic [31:0] rd, sd;
      logic [9:0] sa;
      logic [6:0] smask, rmask, rdmask;
      logic e, w;
      logic [11:0] a;
      logic [31:0] d;
      logic [31:0] wd1;

      tbl[0]  = '{1'b1, 12'h000, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, 12'h004, 32'h12345678, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 12'h004, 32'h0,        1'b0, 32'h12345678};
      tbl[3]  = '{1'b1, 12'h002, 32'h11111111, 1'b1, 32'h0};
      tbl[4]  = '{1'b0, 12'h400, 32'h0,        1'b1, 32'h0};
      tbl[5]  = '{1'b0, 12'h000, 32'h0,        1'b0, 32'hDEADBEEF};
      tbl[6]  = '{1'b1, 12'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 12'h3FC, 32'h0,        1'b0, 32'hA5A5A5A5};
      tbl[8]  = '{1'b0, 12'h801, 32'h0,        1'b1, 32'h0};
      tbl[9]  = '{1'b1, 12'hC00, 32'h55555555, 1'b1, 32'h0};
      tbl[10] = '{1'b0, 12'h002, 32'h0,        1'b1, 32'h0};

      for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
      rst = 1'b1; clr = 1'b1;
      psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      psel0 = 0; penable0 = 0; pwrite0 = 0; paddr0 = 0; pwdata0 = 0;
      repeat (3) @(negedge clk);
      chk("reset.pready", pready, 0);
      chk("reset.pslverr", pslverr, 0);
      chk("reset.wr_en", wr_en, 0);
      chk("reset.rd_en", rd_en, 0);
      chk("reset.prdata", prdata, 0);
      chk("reset.addr", addr, 0);
      chk("reset.wdata", wdata, 0);
      rst = 1'b0; clr = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         do_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].err, tbl[i].prd, $sformatf("vec%0d", i));

      // Reset while waiting: the write must never strobe
      @(negedge clk);
      psel = 1; penable = 0; pwrite = 1; paddr = 12'h010; pwdata = 32'hCAFEF00D;
      @(negedge clk);
      penable = 1;
      rst = 1'b1;
      #1;
      chk("rstwait.wr_en", wr_en, 0);
      chk("rstwait.pready", pready, 0);
      chk("rstwait.pslverr", pslverr, 0);
      chk("rstwait.prdata", prdata, 0);
      chk("rstwait.addr", addr, 0);
      chk("rstwait.wdata", wdata, 0);
      @(negedge clk);
      rst = 1'b0; psel = 0; penable = 0;
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (wr_en || rd_en || pready) stray++;
      end
      chk("rstwait.quiet", stray, 0);
      do_xfer(1'b0, 12'h000, 32'h0, 1'b0, mdl[0], "rstwait.read0");
      do_xfer(1'b0, 12'h010, 32'h0, 1'b0, mdl[4], "rstwait.read10");

      // psel dropped in WAIT, new setup the very next cycle
      xfer(1'b1, 12'h040, 32'h77778888, 1, sk, ns, sw, rk, re, rd, sa, sd);
      chk("dropwait.strobe_count", ns, 0);
      chk("dropwait.pready_cycle", rk, -1);
      do_xfer(1'b0, 12'h040, 32'h0, 1'b0, mdl[16], "dropwait.follow");
      // psel dropped in STROBE: strobe already out, no pready afterwards
      xfer(1'b0, 12'h000, 32'h0, 2, sk, ns, sw, rk, re, rd, sa, sd);
      chk("dropstrobe.strobe_cycle", sk, 2);
      chk("dropstrobe.pready_cycle", rk, -1);
      do_xfer(1'b0, 12'h3FC, 32'h0, 1'b0, mdl[255], "dropstrobe.follow");
      psel = 0; penable = 0;

      // WAIT_STATES=0, back-to-back writes
      wd1 = 32'hB0B0C0C0;
      smask = '0; rmask = '0; rdmask = '0;
      @(negedge clk);
      psel0 = 1; penable0 = 0; pwrite0 = 1; paddr0 = 12'h008; pwdata0 = 32'h0A0B0C0D;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         smask[k] = wr_en0; rmask[k] = pready0; rdmask[k] = rd_en0 | pslverr0;
         if (k == 4) begin
            chk("ws0.addr2", addr0, 10'h00C);
            chk("ws0.wdata2", wdata0, wd1);
         end
         if (k == 3) begin
            penable0 = 0; paddr0 = 12'h00C; pwdata0 = wd1;
         end else if (k == 6) begin
            psel0 = 0; penable0 = 0;
         end else begin
            penable0 = 1;
         end
      end
      chk("ws0.strobe_cycles", smask, 7'b0010010);
      chk("ws0.pready_cycles", rmask, 7'b0100100);
      chk("ws0.no_rd_or_err", rdmask, 0);
      chk("ws0.prdata", prdata0, 0);

      // Randomized transfers against the model
      for (int i = 0; i < 60; i++) begin
         int gap;
         gap = $urandom % 3;
         if (gap != 0) begin
            @(negedge clk);
            psel = 0; penable = 0;
            repeat (gap - 1) @(negedge clk);
         end
         w = 1'($urandom % 2);
         a = 12'($urandom) & 12'h3FC;
         case ($urandom % 8)
            0: a[1:0] = 2'($urandom_range(1, 3));
            1: a[11:10] = 2'($urandom_range(1, 3));
            default: ;
         endcase
         d = $urandom;
         e = mdl_err(a);
         do_xfer(w, a, d, e, (!w && !e) ? mdl[a[9:2]] : 32'h0, $sformatf("rnd%0d", i));
      end
      @(negedge clk);
      psel = 0; penable = 0;
      repeat (2) @(negedge clk);

      chk("mon.both_strobes", both_cnt, 0);
      chk("mon.pslverr_without_pready", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
